// File: rtl/muldiv16_seq_if.sv
// Handshake and result bundle between the processor control FSM and muldiv16_seq.
// The control side drives start/op/operands; the unit returns busy/done and results.
interface muldiv16_seq_if #(parameter int WIDTH = 16);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             divz;
   logic             ovfl;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, divz, ovfl
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, divz, ovfl
   );
endinterface

// File: rtl/muldiv16_seq.sv
// Iterative 16x16 multiply (shift-add) and 16/16 divide (restoring) with start/done handshake.
// Signed ops work on magnitudes and fix the signs up in a final cycle.
module muldiv16_seq #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   muldiv16_seq_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_ITER = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + ONE_W;
   endfunction

   function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
   endfunction

   logic [2:0]       state_r;
   logic [CW-1:0]    cnt_r;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   logic [WIDTH-1:0] x_r;      // mul: |multiplicand|, div: |divisor|
   logic [WIDTH-1:0] acc_r;    // mul: product upper half, div: partial remainder
   logic [WIDTH-1:0] q_r;      // mul: multiplier / product lower half, div: dividend / quotient
   logic             res_neg_r, rem_neg_r, dz_r;
   logic             busy_r, done_r, divz_r, ovfl_r;
   logic [WIDTH-1:0] hi_r, lo_r;

   logic             sgn_s, is_div_s, ovf_s;
   logic [WIDTH:0]   add_s, rsh_s, trial_s;
   logic [2*WIDTH-1:0] prod_s, prod_neg_s;

   // Per-iteration datapath and final-cycle helpers.
   always_comb begin
      sgn_s      = ~op_r[0];
      is_div_s   = op_r[1];
      add_s      = q_r[0] ? ({1'b0, acc_r} + {1'b0, x_r}) : {1'b0, acc_r};
      rsh_s      = {acc_r, q_r[WIDTH-1]};
      trial_s    = rsh_s - {1'b0, x_r};
      prod_s     = {acc_r, q_r};
      prod_neg_s = ~prod_s + ONE_2W;
      ovf_s      = (op_r == 2'b10) && (a_r == MIN_W) && (b_r == ONES_W);
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
   assign bus.divz = divz_r;
   assign bus.ovfl = ovfl_r;

   // Control FSM, iteration registers and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         cnt_r     <= {CW{1'b0}};
         op_r      <= 2'b00;
         a_r       <= ZERO_W;
         b_r       <= ZERO_W;
         x_r       <= ZERO_W;
         acc_r     <= ZERO_W;
         q_r       <= ZERO_W;
         res_neg_r <= 1'b0;
         rem_neg_r <= 1'b0;
         dz_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         divz_r    <= 1'b0;
         ovfl_r    <= 1'b0;
         hi_r      <= ZERO_W;
         lo_r      <= ZERO_W;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  op_r    <= bus.op;
                  busy_r  <= 1'b1;
                  state_r <= S_LOAD;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_LOAD: begin
               acc_r     <= ZERO_W;
               cnt_r     <= {CW{1'b0}};
               res_neg_r <= sgn_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               rem_neg_r <= sgn_s & a_r[WIDTH-1];
               if (is_div_s) begin
                  x_r <= mag_w(b_r, sgn_s);
                  q_r <= mag_w(a_r, sgn_s);
               end else begin
                  x_r <= mag_w(a_r, sgn_s);
                  q_r <= mag_w(b_r, sgn_s);
               end
               // Divide by zero publishes its result now and only passes through FIX.
               if (is_div_s && (b_r == ZERO_W)) begin
                  hi_r    <= a_r;
                  lo_r    <= ONES_W;
                  divz_r  <= 1'b1;
                  ovfl_r  <= 1'b0;
                  dz_r    <= 1'b1;
                  state_r <= S_FIX;
               end else begin
                  dz_r    <= 1'b0;
                  state_r <= S_ITER;
               end
            end
            S_ITER: begin
               if (is_div_s) begin
                  if (!trial_s[WIDTH]) begin
                     acc_r <= trial_s[WIDTH-1:0];
                     q_r   <= {q_r[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_r <= rsh_s[WIDTH-1:0];
                     q_r   <= {q_r[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_r <= add_s[WIDTH:1];
                  q_r   <= {add_s[0], q_r[WIDTH-1:1]};
               end
               if (cnt_r == CNT_LAST) begin
                  state_r <= S_FIX;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
               end
            end
            S_FIX: begin
               if (!dz_r) begin
                  if (is_div_s) begin
                     lo_r <= res_neg_r ? neg_w(q_r) : q_r;
                     hi_r <= rem_neg_r ? neg_w(acc_r) : acc_r;
                  end else begin
                     {hi_r, lo_r} <= res_neg_r ? prod_neg_s : prod_s;
                  end
                  divz_r <= 1'b0;
                  ovfl_r <= ovf_s;
               end
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               state_r <= S_DONE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv16_seq.sv
// Randomized and directed self-checking bench for muldiv16_seq against an arithmetic reference model.
module tb_muldiv16_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv16_seq_if #(.WIDTH(16)) bus ();
   muldiv16_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [15:0] e_hi, e_lo;
   logic        e_divz, e_ovfl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference results straight from integer arithmetic.
   task automatic model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      int sa, sb, q, r;
      logic [31:0] u;
      sa = int'($signed(a));
      sb = int'($signed(b));
      e_divz = 1'b0;
      e_ovfl = 1'b0;
      case (op)
         2'b00: begin q = sa * sb; {e_hi, e_lo} = q; end
         2'b01: begin u = {16'h0000, a} * {16'h0000, b}; {e_hi, e_lo} = u; end
         default: begin
            if (b == 16'h0000) begin
               e_lo = 16'hFFFF; e_hi = a; e_divz = 1'b1;
            end else if (op == 2'b10 && a == 16'h8000 && b == 16'hFFFF) begin
               e_lo = 16'h8000; e_hi = 16'h0000; e_ovfl = 1'b1;
            end else if (op == 2'b10) begin
               q = sa / sb; r = sa % sb;
               e_lo = q[15:0]; e_hi = r[15:0];
            end else begin
               e_lo = a / b; e_hi = a % b;
            end
         end
      endcase
   endtask

   task automatic launch(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.op = 2'($urandom);
   endtask

   // Counts edges after the accepting edge until done; optionally pulses start at edge inj_at+1.
   task automatic wait_done(input string tag, input int exp_lat, input int inj_at);
      int lat;
      lat = 999;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = i;
            break;
         end
         if (i == inj_at) begin
            bus.start = 1'b1; bus.op = 2'b11; bus.a = 16'h7777; bus.b = 16'h0003;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      chk({tag, "_lat"}, lat, exp_lat);
   endtask

   task automatic check_res(input string tag);
      chk({tag, "_hi"}, bus.hi, e_hi);
      chk({tag, "_lo"}, bus.lo, e_lo);
      chk({tag, "_divz"}, bus.divz, e_divz);
      chk({tag, "_ovfl"}, bus.ovfl, e_ovfl);
      chk({tag, "_busy"}, bus.busy, 1'b0);
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [15:0] a,
                      input logic [15:0] b, input int inj_at);
      model(op, a, b);
      launch(op, a, b);
      wait_done(tag, (op[1] && b == 16'h0000) ? 2 : 18, inj_at);
      check_res(tag);
      @(negedge clk);
      chk({tag, "_pulse"}, bus.done, 1'b0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk(tag, seen, 0);
   endtask

   logic [1:0]  d_op [0:7] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10};
   logic [15:0] d_a  [0:7] = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'd100, 16'h8000, 16'd1234, 16'd10, 16'h0005};
   logic [15:0] d_b  [0:7] = '{16'h0007, 16'hFFFF, 16'h0002, 16'd7, 16'hFFFF, 16'h0000, 16'd3, 16'h0000};

   initial begin
      logic [1:0]  rop;
      logic [15:0] ra, rb;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = 16'h0000; bus.b = 16'h0000;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_hilo", {bus.hi, bus.lo}, 32'h0);
      chk("rst_flags", {bus.divz, bus.ovfl}, 2'b00);

      for (int i = 0; i < 8; i++) run($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], -1);

      // start during ITER is ignored and spawns no second operation
      run("ign", 2'b00, 16'h1234, 16'h0567, 6);
      quiet("ign_nodone", 25);

      // back-to-back: start held in the DONE cycle
      model(2'b10, 16'hFF00, 16'h0013);
      launch(2'b10, 16'hFF00, 16'h0013);
      wait_done("b2b1", 18, -1);
      check_res("b2b1");
      model(2'b01, 16'hABCD, 16'h1234);
      launch(2'b01, 16'hABCD, 16'h1234);
      wait_done("b2b2", 18, -1);
      check_res("b2b2");
      @(negedge clk);

      for (int n = 0; n < 60; n++) begin
         rop = 2'($urandom);
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         if ($urandom_range(0, 7) == 0) rb = 16'h0000;
         if ($urandom_range(0, 15) == 0) begin ra = 16'h8000; rb = 16'hFFFF; end
         run($sformatf("rnd%0d", n), rop, ra, rb, -1);
      end

      // reset in the middle of an operation
      run("pre_rst", 2'b00, 16'hFFFD, 16'h0007, -1);
      launch(2'b11, 16'h5000, 16'h0003);
      repeat (10) @(negedge clk);
      chk("mid_busy", bus.busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_out", {bus.busy, bus.done, bus.divz, bus.ovfl, bus.hi, bus.lo}, 36'h0);
      rst_n = 1'b1;
      quiet("mid_nodone", 30);
      chk("mid_idle_out", {bus.busy, bus.hi, bus.lo}, 33'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
